// File: rtl/sysbus_master.sv
// rtl/sysbus_master.sv - sysbus block read/write initiator
module sysbus_master #(
    parameter  int WORD_W = 8,
    parameter  int OP_W   = 3,
    localparam int ADDR_W = WORD_W - OP_W
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              start,
    input  logic              write,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              load_MAR,
    output logic              load_MDR,
    output logic              CS,
    output logic              R_NW,
    output logic              MDR_bus,
    inout  wire  [WORD_W-1:0] sysbus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        RD_CS   = 3'd2,
        RD_BUS  = 3'd3,
        WR_DATA = 3'd4,
        WR_CS   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                wr_dir;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     count;
    logic                bus_drive;
    logic [WORD_W-1:0]   bus_out;
    logic                end_beat;

    assign end_beat = (state == RD_BUS) || (state == WR_CS);

    // The master only ever drives the bus for an address phase or an accepted write word.
    assign sysbus = bus_drive ? bus_out : {WORD_W{1'bz}};

    // State register; reset drops any beat in flight, so an interrupted write never reaches WR_CS.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : ADDR;
                end
            end
            ADDR:    state_next = wr_dir ? WR_DATA : RD_CS;
            RD_CS:   state_next = RD_BUS;
            RD_BUS:  state_next = (count == {{ADDR_W{1'b0}}, 1'b1}) ? DONE : ADDR;
            WR_DATA: state_next = wr_valid ? WR_CS : WR_DATA;
            WR_CS:   state_next = (count == {{ADDR_W{1'b0}}, 1'b1}) ? DONE : ADDR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus control decode; R_NW idles high so a responder never sees a stray write.
    always_comb begin
        load_MAR  = 1'b0;
        load_MDR  = 1'b0;
        CS        = 1'b0;
        R_NW      = 1'b1;
        MDR_bus   = 1'b0;
        wr_ready  = 1'b0;
        bus_drive = 1'b0;
        bus_out   = '0;
        case (state)
            ADDR: begin
                load_MAR  = 1'b1;
                bus_drive = 1'b1;
                bus_out   = {{OP_W{1'b0}}, addr};
            end
            RD_CS: begin
                CS = 1'b1;
            end
            RD_BUS: begin
                CS      = 1'b1;
                MDR_bus = 1'b1;
            end
            WR_DATA: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    load_MDR  = 1'b1;
                    bus_drive = 1'b1;
                    bus_out   = wr_data;
                end
            end
            WR_CS: begin
                CS   = 1'b1;
                R_NW = 1'b0;
            end
            default: ;
        endcase
    end

    // Command capture, address/count stepping and registered status outputs.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            wr_dir   <= 1'b0;
            addr     <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_valid <= (state == RD_BUS);
            done     <= (state == DONE);
            busy     <= (state_next != IDLE);
            if (state == IDLE && start) begin
                wr_dir <= write;
                addr   <= base_addr;
                count  <= len;
            end
            if (state == RD_BUS) begin
                rd_data <= sysbus;
            end
            if (end_beat) begin
                addr  <= addr + 1'b1;
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sysbus_master.sv
// tb/tb_sysbus_master.sv - directed vector bench for sysbus_master
module tb_sysbus_master;

    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    logic       start = 1'b0;
    logic       write = 1'b0;
    logic [4:0] base_addr = '0;
    logic [5:0] len = '0;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready, rd_valid, busy, done;
    logic       load_MAR, load_MDR, CS, R_NW, MDR_bus;
    logic [7:0] rd_data;
    wire  [7:0] sysbus;

    always #5 clock = ~clock;

    sysbus_master dut (
        .clock(clock), .n_reset(n_reset), .start(start), .write(write),
        .base_addr(base_addr), .len(len), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .done(done), .load_MAR(load_MAR), .load_MDR(load_MDR), .CS(CS),
        .R_NW(R_NW), .MDR_bus(MDR_bus), .sysbus(sysbus)
    );

    // Memory responder: MAR/MDR capture, read fetch on CS, write commit on CS with R_NW low.
    logic [7:0] mem [0:31];
    logic [4:0] mar = '0;
    logic [7:0] mdr = '0;
    logic       init_req = 1'b0;
    assign sysbus = MDR_bus ? mdr : 8'hzz;

    always @(posedge clock) begin
        if (init_req) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h40 + 8'(i);
            mem[5] <= 8'hA7;
        end else begin
            if (load_MAR) mar <= sysbus[4:0];
            if (load_MDR) mdr <= sysbus;
            if (CS && !R_NW) mem[mar] <= mdr;
            if (CS && R_NW && !MDR_bus) mdr <= mem[mar];
        end
    end

    // Event monitor sampled on the falling edge.
    int         cyc = 0;
    int         rd_cnt = 0, done_cnt = 0, wcs_cnt = 0, cs_cnt = 0, mar_cnt = 0, contention = 0;
    logic [7:0] rd_val [0:63];
    int         rd_cyc [0:63];
    int         done_cyc [0:63];
    logic [7:0] mar_val [0:63];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rd_valid) begin
            rd_val[rd_cnt % 64] <= rd_data;
            rd_cyc[rd_cnt % 64] <= cyc;
            rd_cnt <= rd_cnt + 1;
        end
        if (done) begin
            done_cyc[done_cnt % 64] <= cyc;
            done_cnt <= done_cnt + 1;
        end
        if (CS && !R_NW) wcs_cnt <= wcs_cnt + 1;
        if (CS) cs_cnt <= cs_cnt + 1;
        if (load_MAR) begin
            mar_val[mar_cnt % 64] <= sysbus;
            mar_cnt <= mar_cnt + 1;
        end
        if (MDR_bus && sysbus !== mdr) contention <= contention + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    int s_cyc, rd0, dn0, wcs0, cs0, mar0;

    // Issue one command and drive the write stream until done (or a reset cut-off).
    task automatic run_cmd(input logic wr, input logic [4:0] base, input logic [5:0] ln,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input int stall_at, input int stall_len,
                           input int restart_at, input int reset_at);
        logic [7:0] wd [0:2];
        int  idx = 0;
        int  stall_left = 0;
        bit  stall_used = 0;
        bit  finished = 0;
        wd[0] = d0; wd[1] = d1; wd[2] = d2;
        rd0 = rd_cnt; dn0 = done_cnt; wcs0 = wcs_cnt; cs0 = cs_cnt; mar0 = mar_cnt;
        @(posedge clock); #1;
        s_cyc = cyc;
        start = 1'b1; write = wr; base_addr = base; len = ln;
        for (int k = 0; k < 120 && !finished; k++) begin
            if (k > 0) begin
                start = (k == restart_at);
                if (k == restart_at) begin
                    write = 1'b1; base_addr = 5'd0; len = 6'd2;
                end
            end
            if (k == reset_at) n_reset = 1'b0;
            if (reset_at >= 0 && k == reset_at + 2) begin
                n_reset = 1'b1;
                finished = 1;
            end
            if (wr && idx == stall_at && !stall_used) begin
                stall_left = stall_len;
                stall_used = 1;
            end
            if (wr && stall_left == 0 && idx < int'(ln) && idx < 3) begin
                wr_valid = 1'b1;
                wr_data  = wd[idx];
            end else begin
                wr_valid = 1'b0;
            end
            @(negedge clock);
            if (k == 1 && ln != 0 && reset_at < 0) chk("busy_active", busy, 1'b1);
            if (reset_at >= 0 && k == reset_at + 1)
                chk("ctrl_in_reset", {CS, R_NW, wr_ready, busy, load_MDR}, 5'b01000);
            if (wr_ready && wr_valid) idx++;
            else if (wr_ready && stall_left > 0) stall_left--;
            if (done && reset_at < 0) finished = 1;
            @(posedge clock); #1;
        end
        chk("cmd_finished", finished, 1'b1);
        start = 1'b0;
        wr_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic       wr;
        logic [4:0] base;
        logic [5:0] ln;
        logic [7:0] d0, d1, d2;
        int         n_rd;
        int         n_wcs;
        int         n_cs;
        int         lat;
        logic [7:0] first;
        logic [7:0] last;
        logic [4:0] last_addr;
    } vec_t;

    vec_t vecs [0:6];

    initial begin
        vecs[0] = '{1'b0, 5'd5,  6'd1, 8'h00, 8'h00, 8'h00, 1, 0, 2, 5,  8'hA7, 8'hA7, 5'd5};
        vecs[1] = '{1'b0, 5'd10, 6'd4, 8'h00, 8'h00, 8'h00, 4, 0, 8, 14, 8'h4A, 8'h4D, 5'd13};
        vecs[2] = '{1'b0, 5'd30, 6'd3, 8'h00, 8'h00, 8'h00, 3, 0, 6, 11, 8'h5E, 8'h40, 5'd0};
        vecs[3] = '{1'b0, 5'd7,  6'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2,  8'h00, 8'h00, 5'd7};
        vecs[4] = '{1'b1, 5'd12, 6'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2,  8'h4C, 8'h4C, 5'd12};
        vecs[5] = '{1'b1, 5'd2,  6'd2, 8'h11, 8'h22, 8'h00, 0, 2, 2, 8,  8'h11, 8'h22, 5'd3};
        vecs[6] = '{1'b1, 5'd16, 6'd1, 8'h9C, 8'h00, 8'h00, 0, 1, 1, 5,  8'h9C, 8'h9C, 5'd16};

        // Reset held while start toggles.
        init_req = 1'b1;
        @(posedge clock); #1;
        init_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            write = i[0];
            len = 6'd3;
            @(negedge clock);
            chk("reset_ctrl", {load_MAR, load_MDR, CS, MDR_bus, wr_ready, rd_valid, busy, done, R_NW},
                9'b000000001);
            chk("reset_rd_data", rd_data, 8'h00);
            @(posedge clock); #1;
        end
        start = 1'b0;
        n_reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_no_activity", mar_cnt + cs_cnt + done_cnt, 0);

        // Table of single commands.
        for (int v = 0; v < 7; v++) begin
            run_cmd(vecs[v].wr, vecs[v].base, vecs[v].ln, vecs[v].d0, vecs[v].d1, vecs[v].d2,
                    -1, 0, -1, -1);
            chk($sformatf("v%0d_rd_count", v), rd_cnt - rd0, vecs[v].n_rd);
            chk($sformatf("v%0d_wcs_count", v), wcs_cnt - wcs0, vecs[v].n_wcs);
            chk($sformatf("v%0d_cs_count", v), cs_cnt - cs0, vecs[v].n_cs);
            chk($sformatf("v%0d_mar_count", v), mar_cnt - mar0, int'(vecs[v].ln));
            chk($sformatf("v%0d_done_count", v), done_cnt - dn0, 1);
            chk($sformatf("v%0d_done_lat", v), done_cyc[dn0 % 64] - s_cyc, vecs[v].lat);
            chk($sformatf("v%0d_busy_idle", v), busy, 1'b0);
            if (vecs[v].ln != 0)
                chk($sformatf("v%0d_mar_val", v), mar_val[mar0 % 64], {3'b000, vecs[v].base});
            if (vecs[v].n_rd > 0) begin
                chk($sformatf("v%0d_rd_first", v), rd_val[rd0 % 64], vecs[v].first);
                chk($sformatf("v%0d_rd_last", v), rd_val[(rd0 + vecs[v].n_rd - 1) % 64], vecs[v].last);
            end
            if (vecs[v].n_wcs > 0) begin
                chk($sformatf("v%0d_mem_first", v), mem[vecs[v].base], vecs[v].first);
                chk($sformatf("v%0d_mem_last", v), mem[vecs[v].last_addr], vecs[v].last);
            end
        end

        // Single read latency: rd_valid four cycles after start.
        run_cmd(1'b0, 5'd5, 6'd1, 8'h00, 8'h00, 8'h00, -1, 0, -1, -1);
        chk("single_rd_lat", rd_cyc[rd0 % 64] - s_cyc, 4);
        chk("single_rd_data", rd_val[rd0 % 64], 8'hA7);
        chk("single_mar_bus", mar_val[mar0 % 64], 8'h05);

        // Block write with two stalled cycles before the second word, wrapping 31 -> 0.
        run_cmd(1'b1, 5'd30, 6'd3, 8'hA1, 8'hB2, 8'hC3, 1, 2, -1, -1);
        chk("stall_mem30", mem[30], 8'hA1);
        chk("stall_mem31", mem[31], 8'hB2);
        chk("stall_mem0", mem[0], 8'hC3);
        chk("stall_wcs", wcs_cnt - wcs0, 3);
        chk("stall_done_lat", done_cyc[dn0 % 64] - s_cyc, 13);

        // Start pulsed mid-command is ignored.
        run_cmd(1'b0, 5'd8, 6'd4, 8'h00, 8'h00, 8'h00, -1, 0, 3, -1);
        chk("ignore_rd_count", rd_cnt - rd0, 4);
        chk("ignore_done_count", done_cnt - dn0, 1);
        chk("ignore_mar_count", mar_cnt - mar0, 4);
        chk("ignore_rd_last", rd_val[(rd0 + 3) % 64], 8'h4B);
        chk("ignore_wcs", wcs_cnt - wcs0, 0);

        // Reset while parked in WR_DATA with no data offered.
        run_cmd(1'b1, 5'd20, 6'd2, 8'hEE, 8'hDD, 8'h00, 0, 50, -1, 4);
        chk("rst_wcs", wcs_cnt - wcs0, 0);
        chk("rst_cs", cs_cnt - cs0, 0);
        chk("rst_mem20", mem[20], 8'h54);
        chk("rst_mem21", mem[21], 8'h55);
        chk("rst_done", done_cnt - dn0, 0);
        chk("rst_after", {busy, wr_ready, CS, R_NW}, 4'b0001);

        chk("bus_contention", contention, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
